// File: rtl/flagcheck_pkg.sv
// Shared types and helpers for the flag-check sequencer.
// Holds the FSM state type, the default flag length and the index-width helper.
package flagcheck_pkg;

  localparam int FLAG_BYTES_DEF = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RST   = 2'd1,
    FEED  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/flagcheck_sequencer.sv
// Drives keygen/encoder/validator: resets the datapath, streams the flag,
// collects per-byte verdicts and reports pass/fail with the first bad index.
module flagcheck_sequencer
  import flagcheck_pkg::*;
#(
  parameter int FLAG_BYTES   = FLAG_BYTES_DEF,
  parameter int RESET_CYCLES = 2,
  parameter int TIMEOUT      = 64,
  localparam int IDXW        = idx_w(FLAG_BYTES)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [FLAG_BYTES*8-1:0] flag,
  output logic                    dp_reset,
  output logic [7:0]              dp_byte,
  output logic                    dp_valid,
  input  logic                    res_valid,
  input  logic                    res_ok,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    timeout,
  output logic [IDXW-1:0]         fail_idx
);

  localparam int NB = FLAG_BYTES * 8;
  localparam int CW = IDXW + 1;
  localparam int RW = $clog2(RESET_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t          state;
  logic [NB-1:0]   sr;
  logic [IDXW-1:0] bcnt;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nx;
  logic [RW-1:0]   rcnt;
  logic [TW-1:0]   tcnt;
  logic            failed;
  logic            fail_nx;
  logic            fail_hit;
  logic            acc;
  logic            collect;

  // Verdicts count only while streaming or draining, and never past the flag length.
  always_comb begin
    collect  = (state == FEED) || (state == DRAIN);
    acc      = collect && res_valid && (cnt < CW'(FLAG_BYTES));
    cnt_nx   = cnt + CW'(acc);
    fail_hit = acc && !res_ok && !failed;
    fail_nx  = failed | fail_hit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sr       <= '0;
      bcnt     <= '0;
      cnt      <= '0;
      rcnt     <= '0;
      tcnt     <= '0;
      failed   <= 1'b0;
      dp_reset <= 1'b0;
      dp_byte  <= 8'h00;
      dp_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      timeout  <= 1'b0;
      fail_idx <= '0;
    end else begin
      done <= 1'b0;
      if (collect) begin
        cnt    <= cnt_nx;
        failed <= fail_nx;
        if (fail_hit) fail_idx <= cnt[IDXW-1:0];
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            sr       <= flag;
            pass     <= 1'b0;
            timeout  <= 1'b0;
            fail_idx <= '0;
            cnt      <= '0;
            failed   <= 1'b0;
            rcnt     <= '0;
            dp_reset <= 1'b1;
            busy     <= 1'b1;
            state    <= RST;
          end
        end
        RST: begin
          if (rcnt == RW'(RESET_CYCLES - 1)) begin
            dp_reset <= 1'b0;
            dp_valid <= 1'b1;
            dp_byte  <= sr[NB-1 -: 8];
            sr       <= {sr[NB-9:0], 8'h00};
            bcnt     <= '0;
            state    <= FEED;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        FEED: begin
          if (bcnt == IDXW'(FLAG_BYTES - 1)) begin
            dp_valid <= 1'b0;
            dp_byte  <= 8'h00;
            tcnt     <= '0;
            state    <= DRAIN;
          end else begin
            bcnt    <= bcnt + 1'b1;
            dp_byte <= sr[NB-1 -: 8];
            sr      <= {sr[NB-9:0], 8'h00};
          end
        end
        DRAIN: begin
          if (cnt_nx == CW'(FLAG_BYTES)) begin
            pass  <= !fail_nx;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            pass     <= 1'b0;
            timeout  <= 1'b1;
            fail_idx <= cnt_nx[IDXW-1:0];
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flagcheck_sequencer.sv
// Bench for flagcheck_sequencer: latency-2 validator model,
// table of full checks plus hand-written restart/reset sequences.
module tb_flagcheck_sequencer;

  localparam int FB = 24;
  localparam int RC = 2;
  localparam int TO = 64;
  localparam int IW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [FB*8-1:0] flag = '0;
  logic          dp_reset;
  logic [7:0]    dp_byte;
  logic          dp_valid;
  logic          res_valid = 1'b0;
  logic          res_ok = 1'b0;
  logic          busy;
  logic          done;
  logic          pass;
  logic          timeout;
  logic [IW-1:0] fail_idx;

  flagcheck_sequencer #(
    .FLAG_BYTES(FB),
    .RESET_CYCLES(RC),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .flag(flag),
    .dp_reset(dp_reset),
    .dp_byte(dp_byte),
    .dp_valid(dp_valid),
    .res_valid(res_valid),
    .res_ok(res_ok),
    .busy(busy),
    .done(done),
    .pass(pass),
    .timeout(timeout),
    .fail_idx(fail_idx)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] fch(input logic [FB*8-1:0] f, input int k);
    return f[FB*8-1-8*k -: 8];
  endfunction

  // Validator model: verdict two cycles after each streamed byte.
  logic [FB*8-1:0] golden = "shc2024{v3r1l0g_1s_fun!}";
  int   withhold = 0;
  bit   inject = 0;
  logic v1 = 0, v2 = 0, v3 = 0;
  logic [7:0] b1 = 0, b2 = 0, b3 = 0;
  int   vk = 0;

  always @(negedge clk) begin
    v3 = v2; b3 = b2;
    v2 = v1; b2 = b1;
    v1 = dp_valid; b1 = dp_byte;
    if (dp_reset) vk = 0;
    res_valid = 1'b0;
    res_ok = 1'b0;
    if (v3) begin
      if (vk < FB - withhold) begin
        res_valid = 1'b1;
        res_ok = (b3 == fch(golden, vk));
      end
      vk++;
    end
    if (inject && dp_reset) begin
      res_valid = 1'b1;
      res_ok = 1'b0;
    end
  end

  typedef struct {
    logic [FB*8-1:0] f;
    int wh;
    int s1;
    int s2;
    bit inj;
    int ep;
    int et;
    int efi;
    int edc;
  } vec_t;

  vec_t tbl[7];

  task automatic run(input vec_t v, input string nm);
    int dcyc, ndone, nval, nrst, berr, p, t, fi;
    dcyc = 0; ndone = 0; nval = 0; nrst = 0; berr = 0;
    p = 0; t = 0; fi = 0;
    @(negedge clk);
    flag = v.f;
    withhold = v.wh;
    inject = v.inj;
    start = 1'b1;
    for (int n = 1; n <= 110; n++) begin
      @(negedge clk);
      start = (n == v.s1) || (n == v.s2);
      if (dp_valid) begin
        if (nval >= FB || dp_byte != fch(v.f, nval)) berr++;
        nval++;
      end
      if (dp_reset) nrst++;
      if (done) begin
        ndone++;
        if (dcyc == 0) begin
          dcyc = n; p = int'(pass); t = int'(timeout); fi = int'(fail_idx);
        end
      end
    end
    start = 1'b0;
    inject = 0;
    withhold = 0;
    chk({nm, ".pass"}, p, v.ep);
    chk({nm, ".timeout"}, t, v.et);
    chk({nm, ".fail_idx"}, fi, v.efi);
    chk({nm, ".done_cycle"}, dcyc, v.edc);
    chk({nm, ".done_count"}, ndone, 1);
    chk({nm, ".valid_cycles"}, nval, FB);
    chk({nm, ".byte_errors"}, berr, 0);
    chk({nm, ".dp_reset_cycles"}, nrst, RC);
  endtask

  logic [FB*8-1:0] bad_last;
  logic [FB*8-1:0] bad_first;

  initial begin
    int k;
    bad_last = golden;
    bad_last[7:0] = ")";
    bad_first = golden;
    bad_first[FB*8-1 -: 8] = "X";

    tbl[0] = '{golden, 0, 0, 0, 0, 1, 0, 0, 29};
    tbl[1] = '{"shc2024{this_is_wrooong}", 0, 0, 0, 0, 0, 0, 8, 29};
    tbl[2] = '{golden, 3, 0, 0, 0, 0, 1, 21, 91};
    tbl[3] = '{bad_last, 0, 0, 0, 0, 0, 0, 23, 29};
    tbl[4] = '{bad_first, 0, 0, 0, 0, 0, 0, 0, 29};
    tbl[5] = '{golden, 0, 5, 20, 0, 1, 0, 0, 29};
    tbl[6] = '{golden, 0, 0, 0, 1, 1, 0, 0, 29};

    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.dp_reset", int'(dp_reset), 0);
    chk("rst.dp_valid", int'(dp_valid), 0);
    chk("rst.dp_byte", int'(dp_byte), 0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.done", int'(done), 0);
    chk("rst.pass", int'(pass), 0);
    chk("rst.timeout", int'(timeout), 0);
    chk("rst.fail_idx", int'(fail_idx), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run(tbl[i], $sformatf("vec%0d", i));
      repeat (5) @(negedge clk);
    end

    // Start accepted in the done cycle launches a back-to-back check.
    flag = golden;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("b2b.first_done_cycle", k, 29);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b.dp_reset", int'(dp_reset), 1);
    chk("b2b.busy", int'(busy), 1);
    chk("b2b.done_low", int'(done), 0);
    k = 1;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("b2b.second_done_cycle", k, 29);
    chk("b2b.pass", int'(pass), 1);
    repeat (5) @(negedge clk);

    // Reset mid-FEED abandons the check silently.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 2; n <= 15; n++) @(negedge clk);
    chk("midrst.feeding", int'(dp_valid), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst.busy", int'(busy), 0);
    chk("midrst.dp_valid", int'(dp_valid), 0);
    chk("midrst.dp_reset", int'(dp_reset), 0);
    k = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) k++;
    end
    chk("midrst.no_done", k, 0);
    run(tbl[0], "after_rst");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
